// File: rtl/cache_plru_replacement_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// cache_repl_pkg
// Shared definitions for the tree pseudo-LRU replacement controller:
//   - repl_state_e : controller FSM states (INIT sweep, IDLE, RESP)
//   - clog2()      : elaboration-time ceiling log2 for index widths
//   - tree_bits()  : number of tree nodes per set (WAYS-1)
// -----------------------------------------------------------------------------
package cache_repl_pkg;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        IDLE = 2'd1,
        RESP = 2'd2
    } repl_state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return r;
    endfunction

    function automatic int tree_bits(input int ways);
        return ways - 1;
    endfunction

endpackage

// File: rtl/cache_plru_replacement_ctrl_tree.sv
// -----------------------------------------------------------------------------
// plru_tree_logic
// Purely combinational tree-PLRU helper for one set.
// Node 0 is the root, children of node n are 2n+1 / 2n+2; a node bit of 0
// points the victim at the lower half, 1 at the upper half.
// Ports:
//   tree_i         : current tree bits of the set
//   valid_i        : line-valid bits; any invalid way overrides the tree walk
//   way_i          : way being touched / filled
//   victim_o       : lowest invalid way, else the way the tree points at
//   tree_touched_o : tree_i with every node on way_i's path pointing away
// -----------------------------------------------------------------------------
module plru_tree_logic
    import cache_repl_pkg::*;
#(
    parameter  int WAYS   = 4,
    localparam int WAY_W  = clog2(WAYS),
    localparam int TREE_W = tree_bits(WAYS)
) (
    input  logic [TREE_W-1:0] tree_i,
    input  logic [WAYS-1:0]   valid_i,
    input  logic [WAY_W-1:0]  way_i,
    output logic [WAY_W-1:0]  victim_o,
    output logic [TREE_W-1:0] tree_touched_o
);

    logic [WAY_W-1:0] plru_way;
    logic [WAY_W-1:0] invalid_way;
    logic             any_invalid;
    int               walk_node;
    int               touch_node;

    // Walk from the root; each visited node contributes one way bit, MSB first.
    always_comb begin
        walk_node = 0;
        plru_way  = '0;
        for (int lvl = 0; lvl < WAY_W; lvl++) begin
            plru_way[WAY_W-1-lvl] = tree_i[walk_node];
            walk_node = 2 * walk_node + 1 + int'(tree_i[walk_node]);
        end
    end

    // Scan downwards so the lowest-index invalid way is the one that sticks.
    always_comb begin
        any_invalid = 1'b0;
        invalid_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_i[w]) begin
                any_invalid = 1'b1;
                invalid_way = WAY_W'(w);
            end
        end
    end

    assign victim_o = any_invalid ? invalid_way : plru_way;

    // Each node on the path points to the half that does not contain way_i.
    always_comb begin
        touch_node     = 0;
        tree_touched_o = tree_i;
        for (int lvl = 0; lvl < WAY_W; lvl++) begin
            tree_touched_o[touch_node] = ~way_i[WAY_W-1-lvl];
            touch_node = 2 * touch_node + 1 + int'(way_i[WAY_W-1-lvl]);
        end
    end

endmodule

// File: rtl/cache_plru_replacement_ctrl.sv
// -----------------------------------------------------------------------------
// cache_plru_replacement_ctrl
// Tree pseudo-LRU replacement controller for the set-associative I-cache.
// After reset / invalidate an INIT sweep clears one set per cycle; then hit
// touches update recency and the refill engine gets one victim per request.
// Optional build macro: CACHE_REPL_STATS_EN adds evict_count_o, a saturating
// count of acknowledged victims whose set was fully valid.
// Ports:
//   clk_i, rst_ni        : clock, synchronous active-low reset
//   ready_o              : sweep finished, requests/touches accepted
//   invalidate_all_i     : pulse restarting the sweep (abandons a pending RESP)
//   touch_valid_i/_set_i/_way_i : cache hit update
//   victim_req_i/_set_i/_valid_bits_i : victim request from refill engine
//   victim_ack_o, victim_way_o : one-cycle acknowledge with selected way
//   evict_count_o        : (CACHE_REPL_STATS_EN only) true-eviction counter
// -----------------------------------------------------------------------------
module cache_plru_replacement_ctrl
    import cache_repl_pkg::*;
#(
    parameter  int WAYS  = 4,
    parameter  int SETS  = 64,
    localparam int SET_W = clog2(SETS),
    localparam int WAY_W = clog2(WAYS)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    output logic             ready_o,
    input  logic             invalidate_all_i,
    input  logic             touch_valid_i,
    input  logic [SET_W-1:0] touch_set_i,
    input  logic [WAY_W-1:0] touch_way_i,
    input  logic             victim_req_i,
    input  logic [SET_W-1:0] victim_set_i,
    input  logic [WAYS-1:0]  victim_valid_bits_i,
    output logic             victim_ack_o,
    output logic [WAY_W-1:0] victim_way_o
`ifdef CACHE_REPL_STATS_EN
    ,
    output logic [31:0]      evict_count_o
`endif
);

    localparam int TREE_W = tree_bits(WAYS);

    repl_state_e      state_q, state_d;
    logic [SET_W-1:0] init_cnt_q, init_cnt_d;
    logic [WAY_W-1:0] victim_way_q, victim_way_d;
    logic [SET_W-1:0] resp_set_q, resp_set_d;
    // Tree of the victim set with the fill already applied, captured at the
    // request edge so the RESP cycle only has to write it back.
    logic [TREE_W-1:0] fill_tree_q, fill_tree_d;

    logic [SETS-1:0][TREE_W-1:0] tree_q;
    logic [SETS-1:0][TREE_W-1:0] tree_d;

    logic              ready;
    logic              sample_req;
    logic              touch_fire;
    logic [TREE_W-1:0] touch_base;
    logic [TREE_W-1:0] touch_tree;
    logic [TREE_W-1:0] victim_base;
    logic [TREE_W-1:0] fill_tree;
    logic [WAY_W-1:0]  victim_sel;
    logic [WAY_W-1:0]  touch_victim_unused;

    assign ready      = (state_q != INIT);
    assign sample_req = (state_q == IDLE) && victim_req_i;
    assign touch_fire = touch_valid_i && ready && !invalidate_all_i;

    // A touch on the set being filled this cycle builds on the filled tree,
    // so the touch wins on any node both paths share.
    assign touch_base = ((state_q == RESP) && (touch_set_i == resp_set_q))
                        ? fill_tree_q : tree_q[touch_set_i];

    plru_tree_logic #(.WAYS(WAYS)) u_touch_tree (
        .tree_i         (touch_base),
        .valid_i        ({WAYS{1'b1}}),
        .way_i          (touch_way_i),
        .victim_o       (touch_victim_unused),
        .tree_touched_o (touch_tree)
    );

    // Same-cycle touch on the requested set is bypassed into the selection.
    assign victim_base = (touch_fire && (touch_set_i == victim_set_i))
                         ? touch_tree : tree_q[victim_set_i];

    // The selected way is fed back as the fill way, yielding the post-fill tree.
    plru_tree_logic #(.WAYS(WAYS)) u_victim_tree (
        .tree_i         (victim_base),
        .valid_i        (victim_valid_bits_i),
        .way_i          (victim_sel),
        .victim_o       (victim_sel),
        .tree_touched_o (fill_tree)
    );

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= INIT;
            init_cnt_q   <= '0;
            victim_way_q <= '0;
            resp_set_q   <= '0;
            fill_tree_q  <= '0;
        end else begin
            state_q      <= state_d;
            init_cnt_q   <= init_cnt_d;
            victim_way_q <= victim_way_d;
            resp_set_q   <= resp_set_d;
            fill_tree_q  <= fill_tree_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        init_cnt_d   = init_cnt_q;
        victim_way_d = victim_way_q;
        resp_set_d   = resp_set_q;
        fill_tree_d  = fill_tree_q;
        if (invalidate_all_i) begin
            state_d    = INIT;
            init_cnt_d = '0;
        end else begin
            case (state_q)
                INIT: begin
                    init_cnt_d = init_cnt_q + 1'b1;
                    if (init_cnt_q == SET_W'(SETS - 1)) begin
                        state_d = IDLE;
                    end
                end
                IDLE: begin
                    if (sample_req) begin
                        state_d      = RESP;
                        victim_way_d = victim_sel;
                        resp_set_d   = victim_set_i;
                        fill_tree_d  = fill_tree;
                    end
                end
                RESP:    state_d = IDLE;
                default: state_d = INIT;
            endcase
        end
    end

    // Outputs; an invalidate arriving during RESP suppresses the acknowledge.
    always_comb begin
        ready_o      = ready;
        victim_ack_o = (state_q == RESP) && !invalidate_all_i;
    end

    assign victim_way_o = victim_way_q;

    // Per-set tree update. The sweep, touch and fill never collide on one set
    // except touch+fill, which touch_base already merges.
    for (genvar gi = 0; gi < SETS; gi++) begin : g_set
        logic init_hit;
        logic touch_hit;
        logic fill_hit;

        assign init_hit  = (state_q == INIT) && (init_cnt_q == SET_W'(gi));
        assign touch_hit = touch_fire && (touch_set_i == SET_W'(gi));
        assign fill_hit  = (state_q == RESP) && (resp_set_q == SET_W'(gi));

        assign tree_d[gi] = invalidate_all_i ? tree_q[gi]          :
                            init_hit         ? {TREE_W{1'b0}}      :
                            touch_hit        ? touch_tree          :
                            fill_hit         ? fill_tree_q         :
                                               tree_q[gi];
    end

    // Tree contents need no reset: every path to READY runs the clearing sweep.
    always_ff @(posedge clk_i) begin
        tree_q <= tree_d;
    end

`ifdef CACHE_REPL_STATS_EN
    logic        resp_evict_q, resp_evict_d;
    logic [31:0] evict_count_q, evict_count_d;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            resp_evict_q  <= 1'b0;
            evict_count_q <= '0;
        end else begin
            resp_evict_q  <= resp_evict_d;
            evict_count_q <= evict_count_d;
        end
    end

    always_comb begin
        resp_evict_d  = resp_evict_q;
        evict_count_d = evict_count_q;
        if (sample_req) begin
            resp_evict_d = &victim_valid_bits_i;
        end
        if (invalidate_all_i) begin
            evict_count_d = '0;
        end else if ((state_q == RESP) && resp_evict_q && (evict_count_q != 32'hFFFF_FFFF)) begin
            evict_count_d = evict_count_q + 32'd1;
        end
    end

    assign evict_count_o = evict_count_q;
`endif

endmodule

// File: tb/tb_cache_plru_replacement_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cache_plru_replacement_ctrl
// Directed bench for the PLRU replacement controller (WAYS=4, SETS=64).
// Expected ways are hand-derived from the tree rules: root node 0, children
// 2n+1/2n+2, bit 0 -> lower half, touch/fill points every path node away.
// -----------------------------------------------------------------------------
module tb_cache_plru_replacement_ctrl;

    localparam int WAYS  = 4;
    localparam int SETS  = 64;
    localparam int SET_W = 6;
    localparam int WAY_W = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             ready;
    logic             invalidate_all;
    logic             touch_valid;
    logic [SET_W-1:0] touch_set;
    logic [WAY_W-1:0] touch_way;
    logic             victim_req;
    logic [SET_W-1:0] victim_set;
    logic [WAYS-1:0]  victim_valid_bits;
    logic             victim_ack;
    logic [WAY_W-1:0] victim_way;
`ifdef CACHE_REPL_STATS_EN
    logic [31:0]      evict_count;
`endif

    int tests = 0;
    int fails = 0;
    int bad;

    always #5 clk = ~clk;

    cache_plru_replacement_ctrl #(.WAYS(WAYS), .SETS(SETS)) dut (
        .clk_i               (clk),
        .rst_ni              (rst_n),
        .ready_o             (ready),
        .invalidate_all_i    (invalidate_all),
        .touch_valid_i       (touch_valid),
        .touch_set_i         (touch_set),
        .touch_way_i         (touch_way),
        .victim_req_i        (victim_req),
        .victim_set_i        (victim_set),
        .victim_valid_bits_i (victim_valid_bits),
        .victim_ack_o        (victim_ack),
        .victim_way_o        (victim_way)
`ifdef CACHE_REPL_STATS_EN
        ,
        .evict_count_o       (evict_count)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full request/acknowledge transaction with no concurrent touch.
    task automatic victim(input string tag, input logic [SET_W-1:0] s,
                          input logic [WAYS-1:0] v, input logic [WAY_W-1:0] exp);
        victim_req        = 1'b1;
        victim_set        = s;
        victim_valid_bits = v;
        tick();
        check({tag, "_ack"}, 32'(victim_ack), 32'd1);
        check({tag, "_way"}, 32'(victim_way), 32'(exp));
        $display("[TB] %s: set %0d valid %b -> way %0d (expect %0d)", tag, s, v, victim_way, exp);
        victim_req = 1'b0;
        tick();
        check({tag, "_ackdrop"}, 32'(victim_ack), 32'd0);
    endtask

    task automatic touch(input logic [SET_W-1:0] s, input logic [WAY_W-1:0] w);
        touch_valid = 1'b1;
        touch_set   = s;
        touch_way   = w;
        tick();
        touch_valid = 1'b0;
        $display("[TB] touch: set %0d way %0d", s, w);
    endtask

    initial begin
        rst_n             = 1'b0;
        invalidate_all    = 1'b0;
        touch_valid       = 1'b0;
        touch_set         = '0;
        touch_way         = '0;
        victim_req        = 1'b0;
        victim_set        = '0;
        victim_valid_bits = '0;

        // Reset state
        repeat (3) tick();
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_ack", 32'(victim_ack), 32'd0);
        check("rst_way", 32'(victim_way), 32'd0);
`ifdef CACHE_REPL_STATS_EN
        check("rst_evict", evict_count, 32'd0);
`endif

        // Request held across the whole sweep: no ACK until sweep end + 1.
        victim_req        = 1'b1;
        victim_set        = 6'd5;
        victim_valid_bits = 4'b1111;
        rst_n             = 1'b1;
        check("init_cycle1_ready", 32'(ready), 32'd0);
        bad = 0;
        for (int i = 1; i < SETS; i++) begin
            tick();
            if (ready !== 1'b0 || victim_ack !== 1'b0) bad++;
        end
        check("init_low_cycles", 32'(bad), 32'd0);
        tick();
        check("ready_cycle65", 32'(ready), 32'd1);
        check("held_req_noack", 32'(victim_ack), 32'd0);
        tick();
        check("held_req_ack", 32'(victim_ack), 32'd1);
        check("held_req_way", 32'(victim_way), 32'd0);
        $display("[TB] held request: set 5 -> way %0d (expect 0)", victim_way);
        victim_req = 1'b0;
        tick();
        check("held_req_ackdrop", 32'(victim_ack), 32'd0);

        // Set 5: touch way 0 -> victim 2; fill of 2 -> next victim 1.
        touch(6'd5, 2'd0);
        victim("s5_after_touch0", 6'd5, 4'b1111, 2'd2);
        victim("s5_second", 6'd5, 4'b1111, 2'd1);

        // Invalid ways take priority over the tree.
        victim("s9_1011", 6'd9, 4'b1011, 2'd2);
        victim("s9_0111", 6'd9, 4'b0111, 2'd3);
        victim("s9_1110", 6'd9, 4'b1110, 2'd0);

        // Bypass: touch way 0 and request on fresh set 7 together -> way 2.
        touch_valid = 1'b1; touch_set = 6'd7; touch_way = 2'd0;
        victim_req = 1'b1; victim_set = 6'd7; victim_valid_bits = 4'b1111;
        tick();
        touch_valid = 1'b0; victim_req = 1'b0;
        check("s7_bypass_ack", 32'(victim_ack), 32'd1);
        check("s7_bypass_way", 32'(victim_way), 32'd2);
        $display("[TB] bypass: set 7 touch 0 + req -> way %0d (expect 2)", victim_way);
        tick();

        // Set 3: touch 2 + req -> 0; touch 0 in RESP; tree 1,1,1 -> way 3.
        touch_valid = 1'b1; touch_set = 6'd3; touch_way = 2'd2;
        victim_req = 1'b1; victim_set = 6'd3; victim_valid_bits = 4'b1111;
        tick();
        check("s3_bypass_way", 32'(victim_way), 32'd0);
        $display("[TB] bypass: set 3 touch 2 + req -> way %0d (expect 0)", victim_way);
        victim_req = 1'b0; touch_way = 2'd0;
        tick();
        touch_valid = 1'b0;
        victim("s3_after_resp_touch", 6'd3, 4'b1111, 2'd3);

        // Set 11: fill way 0, touch way 2 in RESP; touch owns the root -> way 1.
        victim_req = 1'b1; victim_set = 6'd11; victim_valid_bits = 4'b1111;
        tick();
        check("s11_first_way", 32'(victim_way), 32'd0);
        victim_req = 1'b0;
        touch_valid = 1'b1; touch_set = 6'd11; touch_way = 2'd2;
        tick();
        touch_valid = 1'b0;
        victim("s11_touch_wins", 6'd11, 4'b1111, 2'd1);

        // Different sets in one cycle update independently.
        touch_valid = 1'b1; touch_set = 6'd12; touch_way = 2'd0;
        victim_req = 1'b1; victim_set = 6'd13; victim_valid_bits = 4'b1111;
        tick();
        touch_valid = 1'b0; victim_req = 1'b0;
        check("s13_indep_way", 32'(victim_way), 32'd0);
        tick();
        victim("s12_indep", 6'd12, 4'b1111, 2'd2);

        // Invalidate during RESP: ACK suppressed, sweep restarts.
        victim_req = 1'b1; victim_set = 6'd5; victim_valid_bits = 4'b1111;
        tick();
        victim_req = 1'b0;
        invalidate_all = 1'b1;
        #1;
        check("inv_resp_noack", 32'(victim_ack), 32'd0);
        tick();
        invalidate_all = 1'b0;
        $display("[TB] invalidate_all during RESP");
        check("inv_ready_drop", 32'(ready), 32'd0);
`ifdef CACHE_REPL_STATS_EN
        check("inv_evict_clear", evict_count, 32'd0);
`endif
        bad = 0;
        for (int i = 1; i < SETS; i++) begin
            tick();
            if (ready !== 1'b0 || victim_ack !== 1'b0) bad++;
            // Touch on already-cleared set 0 while not ready must be ignored.
            touch_valid = (i == 10);
            touch_set   = 6'd0;
            touch_way   = 2'd0;
        end
        touch_valid = 1'b0;
        check("inv_low_cycles", 32'(bad), 32'd0);
        tick();
        check("inv_ready_back", 32'(ready), 32'd1);

        victim("inv_s5", 6'd5, 4'b1111, 2'd0);
        victim("inv_s0_touch_ignored", 6'd0, 4'b1111, 2'd0);
        victim("inv_s7", 6'd7, 4'b1111, 2'd0);
`ifdef CACHE_REPL_STATS_EN
        check("evict_three", evict_count, 32'd3);
`endif
        victim("s9_partial", 6'd9, 4'b1011, 2'd2);
`ifdef CACHE_REPL_STATS_EN
        check("evict_partial_nocount", evict_count, 32'd3);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
